// File: rtl/sonar_on_chip.sv
// Sonar echo detector: PDM mic -> 2nd-order CIC -> 2-tap FIR -> |y| > THRESH, with a time-of-flight counter.
// Bus: one-cycle registered ack/read data; CIC/FIR pipeline driven by ce_pdm/ce_pcm, FIR +1 cycle, cmp +2 cycles after PCM.
// No backpressure: a held request is acked every second cycle; SONAR_FIR_EN selects the programmable FIR (else FIR = PCM << 4).
module sonar_on_chip (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_strb_i,
  output logic        wbs_ack_o,
  output logic [15:0] wbs_dat_o,
  input  logic        ce_pdm,
  input  logic        ce_pcm,
  input  logic        pdm_data_i,
  input  logic        mclear,
  output logic        cmp
);

  // Address bits outside [4:2] are deliberately ignored (registers alias).
  logic unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};

  logic [2:0] sel;
  logic       req;
  logic       wr_req;
  logic       rd_req;

  assign sel    = wbs_adr_i[4:2];
  assign req    = wb_valid_i & ~wbs_ack_o;
  assign wr_req = req & wbs_strb_i;
  assign rd_req = req & ~wbs_strb_i;

  logic        ctrl_en;
  logic [15:0] thresh;
  logic [11:0] pcm;
  logic [15:0] fir;
  logic [15:0] meas_time;
  logic        det;
  logic [15:0] rdata;

`ifdef SONAR_FIR_EN
  logic signed [15:0] coef0;
  logic signed [15:0] coef1;

  // Programmable FIR coefficients, written on the acking edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      coef0 <= 16'sh0800;
      coef1 <= 16'sh0000;
    end else if (wr_req) begin
      if (sel == 3'd2) coef0 <= wbs_dat_i;
      if (sel == 3'd3) coef1 <= wbs_dat_i;
    end
  end
`endif

  // Control and threshold registers; every other offset is read-only.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_en <= 1'b0;
      thresh  <= 16'h0100;
    end else if (wr_req) begin
      if (sel == 3'd0) ctrl_en <= wbs_dat_i[0];
      if (sel == 3'd1) thresh  <= wbs_dat_i;
    end
  end

  // Read mux; unused CTRL/STATUS bits are zero.
  always_comb begin
    rdata = 16'h0000;
    case (sel)
      3'd0: rdata = {15'h0000, ctrl_en};
      3'd1: rdata = thresh;
`ifdef SONAR_FIR_EN
      3'd2: rdata = coef0;
      3'd3: rdata = coef1;
`endif
      3'd4: rdata = {{4{pcm[11]}}, pcm};
      3'd5: rdata = fir;
      3'd6: rdata = meas_time;
      3'd7: rdata = {15'h0000, det};
      default: rdata = 16'h0000;
    endcase
  end

  // Ack pulses for one cycle per request; read data only in the ack cycle of a read.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 16'h0000;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_req ? rdata : 16'h0000;
    end
  end

  // CIC: integrators wrap at 12 bits; the comb sees the integrator value of this same cycle.
  logic [11:0] integ1;
  logic [11:0] integ2;
  logic [11:0] integ1_nx;
  logic [11:0] integ2_nx;
  logic [11:0] comb_d1;
  logic [11:0] comb_d2;
  logic [11:0] comb1;

  // Next integrator state, including the +1/-1 mapping of the PDM bit.
  always_comb begin
    integ1_nx = integ1;
    integ2_nx = integ2;
    if (ce_pdm) begin
      integ1_nx = integ1 + (pdm_data_i ? 12'h001 : 12'hFFF);
      integ2_nx = integ2 + integ1_nx;
    end
    comb1 = integ2_nx - comb_d1;
  end

  // Integrator and comb state; PCM changes only on ce_pcm.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      integ1  <= 12'h000;
      integ2  <= 12'h000;
      comb_d1 <= 12'h000;
      comb_d2 <= 12'h000;
      pcm     <= 12'h000;
    end else begin
      integ1 <= integ1_nx;
      integ2 <= integ2_nx;
      if (ce_pcm) begin
        comb_d1 <= integ2_nx;
        comb_d2 <= comb1;
        pcm     <= comb1 - comb_d2;
      end
    end
  end

  logic        pcm_upd;
  logic        fir_upd;
  logic [15:0] fir_nx;

`ifdef SONAR_FIR_EN
  logic signed [15:0] x_cur;
  logic signed [15:0] x_prev;
  logic signed [31:0] prod0;
  logic signed [31:0] prod1;
  logic signed [32:0] fir_acc;
  logic signed [32:0] fir_shr;

  // Full-precision 2-tap sum, arithmetic shift, then saturate to 16 bits.
  always_comb begin
    x_cur   = {{4{pcm[11]}}, pcm};
    prod0   = 32'(coef0) * 32'(x_cur);
    prod1   = 32'(coef1) * 32'(x_prev);
    fir_acc = 33'(prod0) + 33'(prod1);
    fir_shr = fir_acc >>> 11;
    if (fir_shr > 33'sd32767)
      fir_nx = 16'h7FFF;
    else if (fir_shr < -33'sd32768)
      fir_nx = 16'h8000;
    else
      fir_nx = fir_shr[15:0];
  end

  // FIR delay line; mclear empties it so a new measurement starts clean.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      x_prev <= 16'sh0000;
    else if (mclear)
      x_prev <= 16'sh0000;
    else if (pcm_upd)
      x_prev <= x_cur;
  end
`else
  // Without the FIR the output is the PCM scaled into the 16-bit range.
  always_comb begin
    fir_nx = {pcm, 4'h0};
  end
`endif

  // FIR lags PCM by one cycle; cmp lags FIR by one more.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pcm_upd <= 1'b0;
      fir_upd <= 1'b0;
      fir     <= 16'h0000;
    end else begin
      pcm_upd <= ce_pcm;
      fir_upd <= pcm_upd;
      if (pcm_upd) fir <= fir_nx;
    end
  end

  // Magnitude is 17 bits so that |-32768| compares correctly.
  logic [16:0] fir_abs;
  always_comb begin
    fir_abs = fir[15] ? (17'h00000 - {1'b1, fir}) : {1'b0, fir};
  end

  // Comparator re-evaluated once per FIR result.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      cmp <= 1'b0;
    else if (fir_upd)
      cmp <= fir_abs > {1'b0, thresh};
  end

  logic det_fire;
  assign det_fire = cmp & ctrl_en & ~det;

  // Time-of-flight counter and sticky detect; mclear overrides both, detection freezes counting.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      meas_time <= 16'h0000;
      det       <= 1'b0;
    end else if (mclear) begin
      meas_time <= 16'h0000;
      det       <= 1'b0;
    end else begin
      if (det_fire) det <= 1'b1;
      if (ce_pcm && ctrl_en && !det && !det_fire && meas_time != 16'hFFFF)
        meas_time <= meas_time + 16'h0001;
    end
  end

endmodule

// File: tb/tb_sonar_on_chip.sv
// Bench for sonar_on_chip: register table, CIC/FIR steady-state values, counting/detection and reset-during-ack.
// Read expectations are queued when a request is driven and popped when the ack arrives.
// Works with and without SONAR_FIR_EN.
module tb_sonar_on_chip;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wb_valid_i;
  logic [31:0] wbs_adr_i;
  logic [15:0] wbs_dat_i;
  logic        wbs_strb_i;
  logic        wbs_ack_o;
  logic [15:0] wbs_dat_o;
  logic        ce_pdm;
  logic        ce_pcm;
  logic        pdm_data_i;
  logic        mclear;
  logic        cmp;

  sonar_on_chip dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wb_valid_i (wb_valid_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_strb_i (wbs_strb_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .ce_pdm     (ce_pdm),
    .ce_pcm     (ce_pcm),
    .pdm_data_i (pdm_data_i),
    .mclear     (mclear),
    .cmp        (cmp)
  );

`ifdef SONAR_FIR_EN
  localparam logic [15:0] FIR_POS = 16'h0640;  // (2048*1600)>>>11
  localparam logic [15:0] FIR_NEG = 16'hF9C0;  // (1024*-1600*2)>>>11
  localparam logic [15:0] B0_RST  = 16'h0800;
  localparam logic [15:0] B1_RB   = 16'h5555;
`else
  localparam logic [15:0] FIR_POS = 16'h6400;  // 1600 << 4
  localparam logic [15:0] FIR_NEG = 16'h9C00;  // -1600 << 4
  localparam logic [15:0] B0_RST  = 16'h0000;
  localparam logic [15:0] B1_RB   = 16'h0000;
`endif

  localparam logic [31:0] A_CTRL = 32'h00, A_THR = 32'h04, A_B0 = 32'h08, A_B1 = 32'h0C;
  localparam logic [31:0] A_PCM = 32'h10, A_FIR = 32'h14, A_TIME = 32'h18, A_STAT = 32'h1C;

  typedef struct {
    bit          wr;
    logic [31:0] adr;
    logic [15:0] wdat;
    logic [15:0] exp;
  } vec_t;

  vec_t        vec [0:20];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Handshake to the enable generator: budget -1 free-runs, N>0 gives N ce_pcm pulses then stops.
  int req_budget = 0;
  int req_id     = 0;
  int pcm_count  = 0;

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ce_pdm every cycle while active, ce_pcm every 40th cycle.
  initial begin
    int seen;
    int budget;
    int cnt;
    seen = 0; budget = 0; cnt = 0;
    ce_pdm = 1'b0;
    ce_pcm = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (req_id != seen) begin
        budget = req_budget;
        seen   = req_id;
      end
      if (budget != 0) begin
        ce_pdm = 1'b1;
        if (cnt == 39) begin
          ce_pcm = 1'b1;
          cnt    = 0;
          pcm_count++;
          if (budget > 0) budget--;
        end else begin
          ce_pcm = 1'b0;
          cnt++;
        end
      end else begin
        ce_pdm = 1'b0;
        ce_pcm = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One bus transfer; ack must arrive exactly one cycle after the request.
  task automatic bus(input bit wr, input logic [31:0] adr, input logic [15:0] wd,
                     input logic [15:0] exp, input string nm);
    int          lat;
    bit          got;
    logic [15:0] e;
    @(negedge wb_clk_i);
    wb_valid_i = 1'b1;
    wbs_adr_i  = adr;
    wbs_dat_i  = wd;
    wbs_strb_i = wr;
    if (!wr) exp_q.push_back(exp);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 8) begin
      @(negedge wb_clk_i);
      lat++;
      if (wbs_ack_o) got = 1'b1;
    end
    wb_valid_i = 1'b0;
    check({nm, "_ack_lat"}, lat, 1);
    if (!wr) begin
      e = exp_q.pop_front();
      if (got) check(nm, {16'h0, wbs_dat_o}, {16'h0, e});
    end
  endtask

  task automatic run_pcm(input int n, input bit free, input string nm);
    int start;
    int waited;
    start      = pcm_count;
    req_budget = free ? -1 : n;
    req_id++;
    waited = 0;
    while (pcm_count < start + n && waited < 50 * n + 100) begin
      @(negedge wb_clk_i);
      waited++;
    end
    check(nm, 32'(pcm_count >= start + n), 1);
    repeat (4) @(negedge wb_clk_i);
  endtask

  initial begin
    wb_rst_i   = 1'b1;
    wb_valid_i = 1'b0;
    wbs_adr_i  = 32'h0;
    wbs_dat_i  = 16'h0;
    wbs_strb_i = 1'b0;
    pdm_data_i = 1'b1;
    mclear     = 1'b0;

    vec[0]  = '{1'b0, A_THR,          16'h0000, 16'h0100};
    vec[1]  = '{1'b0, A_CTRL,         16'h0000, 16'h0000};
    vec[2]  = '{1'b0, A_B0,           16'h0000, B0_RST};
    vec[3]  = '{1'b0, A_B1,           16'h0000, 16'h0000};
    vec[4]  = '{1'b0, A_PCM,          16'h0000, 16'h0000};
    vec[5]  = '{1'b0, A_FIR,          16'h0000, 16'h0000};
    vec[6]  = '{1'b0, A_TIME,         16'h0000, 16'h0000};
    vec[7]  = '{1'b0, A_STAT,         16'h0000, 16'h0000};
    vec[8]  = '{1'b1, A_THR,          16'h1234, 16'h0000};
    vec[9]  = '{1'b0, A_THR,          16'h0000, 16'h1234};
    vec[10] = '{1'b0, 32'h20,         16'h0000, 16'h0000};
    vec[11] = '{1'b1, A_B1,           16'h5555, 16'h0000};
    vec[12] = '{1'b0, A_B1,           16'h0000, B1_RB};
    vec[13] = '{1'b1, A_B1,           16'h0000, 16'h0000};
    vec[14] = '{1'b1, A_PCM,          16'hAAAA, 16'h0000};
    vec[15] = '{1'b0, A_PCM,          16'h0000, 16'h0000};
    vec[16] = '{1'b1, A_CTRL,         16'hFFFF, 16'h0000};
    vec[17] = '{1'b0, A_CTRL,         16'h0000, 16'h0001};
    vec[18] = '{1'b1, A_CTRL,         16'h0000, 16'h0000};
    vec[19] = '{1'b0, A_CTRL,         16'h0000, 16'h0000};
    vec[20] = '{1'b0, 32'h8000_0007,  16'h0000, 16'h1234};

    // Reset state
    repeat (3) @(negedge wb_clk_i);
    check("rst_ack", {31'h0, wbs_ack_o}, 0);
    check("rst_dat", {16'h0, wbs_dat_o}, 0);
    check("rst_cmp", {31'h0, cmp}, 0);
    wb_rst_i = 1'b0;

    // Register table
    for (int i = 0; i < 21; i++)
      bus(vec[i].wr, vec[i].adr, vec[i].wdat, vec[i].exp, $sformatf("vec%0d", i));

    // Held request: ack every second cycle, data only in ack cycles
    @(negedge wb_clk_i);
    wb_valid_i = 1'b1;
    wbs_adr_i  = A_THR;
    wbs_strb_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      check($sformatf("hold_ack%0d", i), {31'h0, wbs_ack_o}, (i % 2 == 0) ? 1 : 0);
      check($sformatf("hold_dat%0d", i), {16'h0, wbs_dat_o}, (i % 2 == 0) ? 32'h1234 : 0);
    end
    wb_valid_i = 1'b0;

    // CIC/FIR steady state, all-ones PDM
    pdm_data_i = 1'b1;
    run_pcm(6, 1'b1, "run_pos");
    bus(1'b0, A_PCM, 16'h0, 16'h0640, "pcm_pos");
    bus(1'b0, A_FIR, 16'h0, FIR_POS, "fir_pos");

    // All-zeros PDM with equal taps
    bus(1'b1, A_B0, 16'h0400, 16'h0, "wr_b0");
    bus(1'b1, A_B1, 16'h0400, 16'h0, "wr_b1");
    pdm_data_i = 1'b0;
    run_pcm(6, 1'b1, "run_neg");
    bus(1'b0, A_PCM, 16'h0, 16'hF9C0, "pcm_neg");
    bus(1'b0, A_FIR, 16'h0, FIR_NEG, "fir_neg");

    // Counting: high threshold, then exactly 10 pulses with EN=1
    bus(1'b1, A_THR, 16'h7FFF, 16'h0, "wr_thr_hi");
    run_pcm(2, 1'b1, "run_settle");
    run_pcm(1, 1'b0, "stop");
    check("cmp_lo", {31'h0, cmp}, 0);
    bus(1'b1, A_CTRL, 16'h0001, 16'h0, "wr_en");
    run_pcm(10, 1'b0, "run10");
    bus(1'b0, A_TIME, 16'h0, 16'd10, "time10");
    bus(1'b0, A_STAT, 16'h0, 16'h0, "det0");

    // Detection: low threshold; one more pulse counts, then detect freezes TIME
    bus(1'b1, A_THR, 16'd100, 16'h0, "wr_thr_lo");
    run_pcm(1, 1'b0, "run_det");
    check("cmp_hi", {31'h0, cmp}, 1);
    bus(1'b0, A_STAT, 16'h0, 16'h1, "det1");
    bus(1'b0, A_TIME, 16'h0, 16'd11, "time11");
    run_pcm(2, 1'b0, "run_frozen");
    bus(1'b0, A_TIME, 16'h0, 16'd11, "time_frozen");
    bus(1'b0, A_STAT, 16'h0, 16'h1, "det_sticky");

    // mclear with EN off so detection cannot re-fire
    bus(1'b1, A_CTRL, 16'h0000, 16'h0, "wr_dis");
    @(negedge wb_clk_i);
    mclear = 1'b1;
    @(negedge wb_clk_i);
    mclear = 1'b0;
    bus(1'b0, A_TIME, 16'h0, 16'h0, "time_clr");
    bus(1'b0, A_STAT, 16'h0, 16'h0, "det_clr");

    // Reset asserted in the ack cycle of a read
    @(negedge wb_clk_i);
    wb_valid_i = 1'b1;
    wbs_adr_i  = A_THR;
    wbs_strb_i = 1'b0;
    @(negedge wb_clk_i);
    check("pre_rst_ack", {31'h0, wbs_ack_o}, 1);
    check("pre_rst_dat", {16'h0, wbs_dat_o}, 32'd100);
    wb_rst_i = 1'b1;
    #1;
    check("arst_ack", {31'h0, wbs_ack_o}, 0);
    check("arst_dat", {16'h0, wbs_dat_o}, 0);
    check("arst_cmp", {31'h0, cmp}, 0);
    wb_valid_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    bus(1'b0, A_THR, 16'h0, 16'h0100, "thr_after_rst");
    bus(1'b0, A_B0, 16'h0, B0_RST, "b0_after_rst");
    bus(1'b0, A_PCM, 16'h0, 16'h0, "pcm_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
